zbt_image_reader: RTL and testbench
===================================

Name: zbt_image_reader

Overview:
Read-side counterpart of the ZBT pixel packer used by the video display path. Streams one frame of 36-bit ZBT words from SRAM, absorbs the fixed ZBT read latency in a small word FIFO, and unpacks each word into four 8-bit pixels. Pixels leave on a valid/ready handshake toward the VGA pixel pipeline.

Parameters:
ADDR_W, 19, ZBT address width
FRAME_WORDS, 76800, words per frame (640x480 pixels / 4)
READ_LATENCY, 2, cycles from zbt_rd_en to valid zbt_rd_data
FIFO_DEPTH, 4, word FIFO entries (power of two, >= READ_LATENCY+1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse to begin a frame; honoured only in IDLE
zbt_addr  out  ADDR_W  ZBT read address
zbt_rd_en  out  1  read request this cycle
zbt_rd_data  in  36  ZBT read data, valid READ_LATENCY cycles after zbt_rd_en
pixel_data  out  8  current pixel
pixel_valid  out  1  pixel_data is valid
pixel_ready  in  1  consumer accepts pixel this cycle
busy  out  1  high outside IDLE
frame_done  out  1  one-cycle pulse after last pixel accepted

Behaviour:
- Reset (reset low, async): state=IDLE, zbt_addr=0, zbt_rd_en=0, pixel_valid=0, pixel_data=0, busy=0, frame_done=0; FIFO, in-flight shift register, byte index, counters cleared. Reads in flight when reset asserts are discarded.
- States: IDLE, RUN, DRAIN.
  - IDLE: start=1 -> RUN; issue counter=0, zbt_addr=0. start outside IDLE is ignored.
  - RUN: zbt_rd_en=1 when fifo_count + inflight < FIFO_DEPTH; each issue increments zbt_addr and the issue counter. When issue counter reaches FRAME_WORDS -> DRAIN. No address wrap within a frame. zbt_addr resets to 0 at next start.
  - DRAIN: no reads. When FIFO empty, inflight=0, and the last byte of the last word is accepted -> frame_done=1 for one cycle, busy drops, next state IDLE.
- Latency tracking: READ_LATENCY-deep valid shift register fed by zbt_rd_en; its tail pushes zbt_rd_data into FIFO. The credit check guarantees the FIFO never overflows; overflow is a design error.
- Unpack: bits [35:32] ignored. Pixel order per word: [31:24], [23:16], [15:8], [7:0]. Byte index 0..3 wraps to 0 and pops the next word on acceptance of byte 3.
- Handshake: transfer when pixel_valid && pixel_ready. After pixel_valid asserts, pixel_data is held stable and pixel_valid stays high until a transfer. A new word loads the same cycle byte 3 transfers if the FIFO is non-empty, so there are no bubbles. Throughput is 1 pixel/clk sustained while pixel_ready=1.
- First-pixel latency from start: 1 (issue) + READ_LATENCY + 1 (FIFO→output register) cycles.
- Simultaneous FIFO push and pop in the same cycle: both occur and the count is unchanged.
- pixel_ready low indefinitely: reads stall via the credit check and no data is lost.

Decomposition:
- Shared package (video/ZBT constants): ZBT_DATA_W=36, PIXEL_W=8, PIXELS_PER_WORD=4, H_ACTIVE=640, V_ACTIVE=480, the state enum {IDLE, RUN, DRAIN}. FRAME_WORDS is derived from the package constants.
- One sub-module: zbt_word_fifo (synchronous FIFO, parameterised width/depth, async active-low reset, push/pop/count/empty/full).

Test Plan:
1. Single word: FRAME_WORDS=1, model returns 36'hFAABBCCDD, pixel_ready=1 -> pixel_data AA,BB,CC,DD on consecutive cycles, first at start+4, then frame_done one cycle after DD accepted, busy=0.
2. Full-rate streaming: FRAME_WORDS=16, word n = {4'h0, n, n, n, n} bytes, pixel_ready=1 -> 64 pixels with no bubbles after the first, zbt_addr 0..15 each issued once, frame_done once.
3. Backpressure: pixel_ready toggles 1,0,0,1 pattern and is held 0 for 20 cycles -> pixel_data stable while stalled, zbt_rd_en drops once FIFO+inflight=4, pixel order intact, no word lost or duplicated.
4. Ignored start: pulse start during RUN -> zbt_addr sequence unaffected, single frame_done.
5. Reset mid-frame: assert reset at word 5 with 2 reads in flight -> all outputs at reset values immediately. Late zbt_rd_data is ignored. New start reads from address 0 and the first pixel is byte [31:24] of word 0.
6. Back-to-back frames: start the cycle after frame_done -> second frame begins at address 0 with identical output.

Source files
------------

// File: rtl/zbt_image_reader_pkg.sv
// zbt_image_reader_pkg: ZBT/video constants and reader state type shared by the read path
package zbt_image_reader_pkg;
  localparam int ZBT_DATA_W = 36;
  localparam int PIXEL_W = 8;
  localparam int PIXELS_PER_WORD = 4;
  localparam int WORD_BITS = PIXEL_W * PIXELS_PER_WORD;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FRAME_WORDS_DEF = H_ACTIVE * V_ACTIVE / PIXELS_PER_WORD;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/zbt_image_reader_if.sv
// zbt_image_reader_if: control, ZBT read bus and pixel handshake of the image reader
interface zbt_image_reader_if #(parameter int ADDR_W = 19);
  import zbt_image_reader_pkg::*;
  logic start;
  logic busy;
  logic frame_done;
  logic [ADDR_W-1:0] zbt_addr;
  logic zbt_rd_en;
  logic [ZBT_DATA_W-1:0] zbt_rd_data;
  logic [PIXEL_W-1:0] pixel_data;
  logic pixel_valid;
  logic pixel_ready;
  modport master (
    input start, zbt_rd_data, pixel_ready,
    output busy, frame_done, zbt_addr, zbt_rd_en, pixel_data, pixel_valid
  );
  modport slave (
    output start, zbt_rd_data, pixel_ready,
    input busy, frame_done, zbt_addr, zbt_rd_en, pixel_data, pixel_valid
  );
endinterface

// File: rtl/zbt_word_fifo.sv
// zbt_word_fifo: synchronous FIFO with occupancy count, async active-low reset
module zbt_word_fifo #(
  parameter int W = 36,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  assign dout_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
endmodule

// File: rtl/zbt_image_reader.sv
// zbt_image_reader: streams one frame of ZBT words through a latency FIFO and unpacks them to pixels
module zbt_image_reader
  import zbt_image_reader_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  zbt_image_reader_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);
  state_t state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [READ_LATENCY-1:0] sr_q;
  logic [WORD_BITS-1:0] word_q;
  logic [1:0] idx_q;
  logic valid_q, done_q;
  logic [ZBT_DATA_W-1:0] fifo_dout;
  logic [CW-1:0] fifo_count;
  logic fifo_empty, fifo_full;
  logic rd_en, xfer, last_byte, load, done_d, unused_bits;
  int occ;
  // words buffered plus words still travelling through the SRAM pipeline
  always_comb begin
    occ = int'(fifo_count);
    for (int i = 0; i < READ_LATENCY; i++) occ += int'(sr_q[i]);
  end
  assign rd_en = state_q == RUN && occ < FIFO_DEPTH;
  assign xfer = valid_q && bus.pixel_ready;
  assign last_byte = xfer && idx_q == 2'd3;
  assign load = !fifo_empty && (!valid_q || last_byte);
  assign done_d = state_q == DRAIN && occ == 0 && last_byte;
  zbt_word_fifo #(.W(ZBT_DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(reset),
    .push_i(sr_q[READ_LATENCY-1]),
    .pop_i(load),
    .din_i(bus.zbt_rd_data),
    .dout_o(fifo_dout),
    .count_o(fifo_count),
    .empty_o(fifo_empty),
    .full_o(fifo_full)
  );
  // addr_q doubles as the issue counter: both restart at zero on start
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      sr_q <= '0;
      word_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= (state_q == IDLE && bus.start) ? RUN :
                 (rd_en && addr_q == LAST) ? DRAIN :
                 done_d ? IDLE : state_q;
      addr_q <= (state_q == IDLE && bus.start) ? '0 : addr_q + ADDR_W'(rd_en);
      sr_q <= READ_LATENCY'({sr_q, rd_en});
      done_q <= done_d;
      word_q <= load ? fifo_dout[WORD_BITS-1:0] : word_q;
      idx_q <= load ? '0 : xfer ? idx_q + 2'd1 : idx_q;
      valid_q <= load | (valid_q & ~last_byte);
    end
  assign bus.zbt_addr = addr_q;
  assign bus.zbt_rd_en = rd_en;
  assign bus.pixel_data = PIXEL_W'(word_q >> {~idx_q, 3'b000});
  assign bus.pixel_valid = valid_q;
  assign bus.busy = state_q != IDLE;
  assign bus.frame_done = done_q;
  assign unused_bits = ^{fifo_dout[ZBT_DATA_W-1:WORD_BITS], fifo_full};
endmodule

// File: tb/tb_zbt_image_reader.sv
// tb_zbt_image_reader: ZBT latency model plus pixel scoreboard for one-word and 16-word frames
module tb_zbt_image_reader;
  import zbt_image_reader_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int pat = 0;
  logic [7:0] q[$];
  logic [18:0] exp_addr;
  logic s1_en1 = 1'b0, s1_en16 = 1'b0;
  logic [18:0] s1_a16 = '0;
  always #5 clk = ~clk;
  zbt_image_reader_if #(.ADDR_W(19)) if1 ();
  zbt_image_reader_if #(.ADDR_W(19)) if16 ();
  zbt_image_reader #(.ADDR_W(19), .FRAME_WORDS(1), .READ_LATENCY(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .reset(reset), .bus(if1.master));
  zbt_image_reader #(.ADDR_W(19), .FRAME_WORDS(16), .READ_LATENCY(2), .FIFO_DEPTH(4)) u16 (
    .clk(clk), .reset(reset), .bus(if16.master));
  function automatic logic [35:0] word16(input logic [18:0] a);
    logic [7:0] n;
    n = a[7:0];
    return pat == 0 ? {4'h0, n, n, n, n} : {4'hA, n, n ^ 8'h40, n ^ 8'h80, n ^ 8'hC0};
  endfunction
  // two-cycle SRAM: request sampled on one edge, data driven on the next
  always @(posedge clk) begin
    s1_en1 <= if1.zbt_rd_en;
    if1.zbt_rd_data <= s1_en1 ? 36'hFAABBCCDD : 36'hF_EEEEEEEE;
    s1_en16 <= if16.zbt_rd_en;
    s1_a16 <= if16.zbt_addr;
    if16.zbt_rd_data <= s1_en16 ? word16(s1_a16) : 36'hF_EEEEEEEE;
  end
  task automatic run_frame(input int mode, input bit stray, input bit tail,
                           output int pixels, output int bubbles, output int dones, output int first_t);
    logic [7:0] prev_data, e;
    logic [35:0] w;
    bit prev_stall, done;
    prev_stall = 0; done = 0; prev_data = '0;
    pixels = 0; bubbles = 0; dones = 0; first_t = -1;
    q = {};
    exp_addr = '0;
    @(posedge clk); #1;
    if16.start = 1'b1;
    if16.pixel_ready = 1'b1;
    for (int t = 0; t < 400 && !done; t++) begin
      @(posedge clk); #1;
      if16.start = stray && t == 6;
      if16.pixel_ready = mode == 0 ? 1'b1 : (t >= 30 && t < 50) ? 1'b0 : (t % 4 == 0 || t % 4 == 3);
      @(negedge clk);
      if (if16.zbt_rd_en) begin
        checks++;
        if (if16.zbt_addr !== exp_addr) begin
          errors++;
          $display("FAIL rd_addr: got %0d expected %0d", if16.zbt_addr, exp_addr);
        end
        w = word16(exp_addr);
        for (int b = 3; b >= 0; b--) q.push_back(w[8*b +: 8]);
        exp_addr++;
      end
      if (if16.pixel_valid && if16.pixel_ready) begin
        if (first_t < 0) first_t = t;
        checks++;
        e = q.size() == 0 ? 8'hxx : q.pop_front();
        if (if16.pixel_data !== e) begin
          errors++;
          $display("FAIL pixel %0d: got %h expected %h", pixels, if16.pixel_data, e);
        end
        pixels++;
      end else if (mode == 0 && first_t >= 0 && pixels < 64) bubbles++;
      if (prev_stall) begin
        checks++;
        if (if16.pixel_valid !== 1'b1 || if16.pixel_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                   if16.pixel_valid, if16.pixel_data, prev_data);
        end
      end
      prev_stall = if16.pixel_valid && !if16.pixel_ready;
      prev_data = if16.pixel_data;
      if (mode == 1 && t >= 40 && t < 50) begin
        checks++;
        if (if16.zbt_rd_en !== 1'b0) begin
          errors++;
          $display("FAIL credit_stall t=%0d: got rd_en=%b expected 0", t, if16.zbt_rd_en);
        end
      end
      if (if16.frame_done) begin
        dones++;
        done = 1;
      end
    end
    if (tail) repeat (3) begin
      @(negedge clk);
      if (if16.frame_done) dones++;
    end
  endtask
  task automatic check_frame(input string name, input int pixels, input int dones, input int first_t);
    checks++;
    if (pixels != 64 || dones != 1 || first_t != 4 || exp_addr != 19'd16 || q.size() != 0 || if16.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got pixels=%0d dones=%0d first=%0d words=%0d left=%0d busy=%b expected 64 1 4 16 0 0",
               name, pixels, dones, first_t, exp_addr, q.size(), if16.busy);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (if16.zbt_addr !== '0 || if16.zbt_rd_en !== 1'b0 || if16.pixel_valid !== 1'b0 ||
        if16.pixel_data !== 8'h00 || if16.busy !== 1'b0 || if16.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset16: got addr=%0d rd=%b v=%b d=%h busy=%b done=%b expected all zero",
               if16.zbt_addr, if16.zbt_rd_en, if16.pixel_valid, if16.pixel_data, if16.busy, if16.frame_done);
    end
    checks++;
    if (if1.zbt_addr !== '0 || if1.zbt_rd_en !== 1'b0 || if1.pixel_valid !== 1'b0 ||
        if1.pixel_data !== 8'h00 || if1.busy !== 1'b0 || if1.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset1: got addr=%0d rd=%b v=%b busy=%b expected all zero",
               if1.zbt_addr, if1.zbt_rd_en, if1.pixel_valid, if1.busy);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (if16.busy !== 1'b0 || if16.zbt_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b rd=%b expected 0 0", if16.busy, if16.zbt_rd_en);
    end
  endtask
  task automatic test_single_word();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
    @(posedge clk); #1;
    if1.start = 1'b1;
    if1.pixel_ready = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (if1.pixel_valid !== (c >= 4 && c <= 7) || (c >= 4 && c <= 7 && if1.pixel_data !== exp_b[c-4])) begin
        errors++;
        $display("FAIL single_pixel c=%0d: got v=%b d=%h", c, if1.pixel_valid, if1.pixel_data);
      end
      checks++;
      if (if1.frame_done !== (c == 8) || if1.busy !== (c < 8)) begin
        errors++;
        $display("FAIL single_ctrl c=%0d: got done=%b busy=%b expected %b %b", c, if1.frame_done, if1.busy, c == 8, c < 8);
      end
      if (c < 2) begin
        checks++;
        if (if1.zbt_rd_en !== (c == 0) || (c == 0 && if1.zbt_addr !== '0)) begin
          errors++;
          $display("FAIL single_issue c=%0d: got rd=%b addr=%0d", c, if1.zbt_rd_en, if1.zbt_addr);
        end
      end
    end
    if1.pixel_ready = 1'b0;
  endtask
  task automatic test_streaming();
    int px, bub, dn, ft;
    pat = 0;
    run_frame(0, 0, 1, px, bub, dn, ft);
    check_frame("streaming", px, dn, ft);
    checks++;
    if (bub != 0) begin
      errors++;
      $display("FAIL bubbles: got %0d expected 0", bub);
    end
  endtask
  task automatic test_backpressure();
    int px, bub, dn, ft;
    pat = 1;
    run_frame(1, 0, 1, px, bub, dn, ft);
    check_frame("backpressure", px, dn, ft);
  endtask
  task automatic test_ignored_start();
    int px, bub, dn, ft;
    pat = 1;
    run_frame(0, 1, 1, px, bub, dn, ft);
    check_frame("ignored_start", px, dn, ft);
  endtask
  task automatic test_reset_mid_frame();
    int px, bub, dn, ft;
    bit found;
    found = 0;
    pat = 0;
    if16.pixel_ready = 1'b1;
    @(posedge clk); #1 if16.start = 1'b1;
    @(posedge clk); #1 if16.start = 1'b0;
    for (int t = 0; t < 60 && !found; t++) begin
      @(negedge clk);
      found = if16.zbt_rd_en && if16.zbt_addr == 19'd5;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_frame_timeout: got no issue of word 5 expected one");
    end
    reset = 1'b0;
    #1;
    checks++;
    if (if16.zbt_addr !== '0 || if16.zbt_rd_en !== 1'b0 || if16.pixel_valid !== 1'b0 ||
        if16.pixel_data !== 8'h00 || if16.busy !== 1'b0 || if16.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got addr=%0d rd=%b v=%b d=%h busy=%b expected all zero",
               if16.zbt_addr, if16.zbt_rd_en, if16.pixel_valid, if16.pixel_data, if16.busy);
    end
    @(posedge clk); #1 reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (if16.pixel_valid !== 1'b0 || if16.busy !== 1'b0 || if16.zbt_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL late_data c=%0d: got v=%b busy=%b rd=%b expected 0 0 0", c, if16.pixel_valid, if16.busy, if16.zbt_rd_en);
      end
    end
    pat = 1;
    run_frame(0, 0, 1, px, bub, dn, ft);
    check_frame("after_reset", px, dn, ft);
  endtask
  task automatic test_back_to_back();
    int px, bub, dn, ft;
    pat = 1;
    run_frame(0, 0, 0, px, bub, dn, ft);
    check_frame("b2b_first", px, dn, ft);
    run_frame(0, 0, 1, px, bub, dn, ft);
    check_frame("b2b_second", px, dn, ft);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    if1.start = 1'b0;
    if1.pixel_ready = 1'b0;
    if16.start = 1'b0;
    if16.pixel_ready = 1'b0;
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_ignored_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
